// File: rtl/img_cmp_ctrl.sv
// Frame-comparison sequencer: reads frames A and B pixel by pixel through one shared
// read port, accumulates per-channel squared differences and flags a thresholded match.
module img_cmp_ctrl #(
    parameter int W_MAX = 640,
    parameter int H_MAX = 480,
    parameter int AW    = 19,
    parameter int ACC_W = 36
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               abort,
    input  logic [9:0]         width,
    input  logic [9:0]         height,
    input  logic [ACC_W+1:0]   thresh,
    output logic               busy,
    output logic               done,
    output logic               size_err,
    output logic               mem_req,
    output logic               mem_sel,
    output logic [AW-1:0]      mem_addr,
    input  logic               mem_ack,
    input  logic [23:0]        mem_rdata,
    output logic [ACC_W-1:0]   sum_r,
    output logic [ACC_W-1:0]   sum_g,
    output logic [ACC_W-1:0]   sum_b,
    output logic [ACC_W+1:0]   total,
    output logic               match
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CHK  = 3'd1,
        S_RD_A = 3'd2,
        S_RD_B = 3'd3,
        S_ACC  = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    localparam logic [9:0] W_MAX_L = 10'(W_MAX);
    localparam logic [9:0] H_MAX_L = 10'(H_MAX);

    function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        abs_diff = (a >= b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [15:0] sq8(input logic [7:0] d);
        sq8 = {8'd0, d} * {8'd0, d};
    endfunction

    // Saturating accumulate: once the sum would overflow it sticks at all-ones.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc, input logic [15:0] inc);
        logic [ACC_W:0] s;
        s = {1'b0, acc} + {{(ACC_W-15){1'b0}}, inc};
        sat_add = s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_busy;
    logic               r_done;
    logic               r_mem_req;
    logic               r_mem_sel;
    logic               r_size_err;
    logic               r_match;
    logic [9:0]         r_width;
    logic [9:0]         r_height;
    logic [ACC_W+1:0]   r_thresh;
    logic [AW-1:0]      r_pix;
    logic [19:0]        r_last;
    logic [23:0]        r_pix_a;
    logic [23:0]        r_pix_b;
    logic [ACC_W-1:0]   r_sum_r;
    logic [ACC_W-1:0]   r_sum_g;
    logic [ACC_W-1:0]   r_sum_b;
    logic [ACC_W+1:0]   r_total;

    logic               w_size_bad;
    logic [19:0]        w_n;
    logic [19:0]        w_last;
    logic               w_pix_last;
    logic [15:0]        w_sq_r;
    logic [15:0]        w_sq_g;
    logic [15:0]        w_sq_b;
    logic [ACC_W-1:0]   w_sum_r_nxt;
    logic [ACC_W-1:0]   w_sum_g_nxt;
    logic [ACC_W-1:0]   w_sum_b_nxt;
    logic [ACC_W+1:0]   w_total_nxt;

    assign w_size_bad  = (r_width == 10'd0) || (r_height == 10'd0) ||
                         (r_width > W_MAX_L) || (r_height > H_MAX_L);
    assign w_n         = {10'd0, r_width} * {10'd0, r_height};
    assign w_last      = w_n - 20'd1;
    assign w_pix_last  = ({{(20-AW){1'b0}}, r_pix} == r_last);

    assign w_sq_r      = sq8(abs_diff(r_pix_a[23:16], r_pix_b[23:16]));
    assign w_sq_g      = sq8(abs_diff(r_pix_a[15:8],  r_pix_b[15:8]));
    assign w_sq_b      = sq8(abs_diff(r_pix_a[7:0],   r_pix_b[7:0]));
    assign w_sum_r_nxt = sat_add(r_sum_r, w_sq_r);
    assign w_sum_g_nxt = sat_add(r_sum_g, w_sq_g);
    assign w_sum_b_nxt = sat_add(r_sum_b, w_sq_b);
    assign w_total_nxt = {2'b00, w_sum_r_nxt} + {2'b00, w_sum_g_nxt} + {2'b00, w_sum_b_nxt};

    // Next-state logic; abort beats a coincident ack so that read is dropped.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_CHK;
                else       w_state_nxt = S_IDLE;
            end
            S_CHK: begin
                if (abort)           w_state_nxt = S_IDLE;
                else if (w_size_bad) w_state_nxt = S_FIN;
                else                 w_state_nxt = S_RD_A;
            end
            S_RD_A: begin
                if (abort)        w_state_nxt = S_IDLE;
                else if (mem_ack) w_state_nxt = S_RD_B;
                else              w_state_nxt = S_RD_A;
            end
            S_RD_B: begin
                if (abort)        w_state_nxt = S_IDLE;
                else if (mem_ack) w_state_nxt = S_ACC;
                else              w_state_nxt = S_RD_B;
            end
            S_ACC: begin
                if (abort)           w_state_nxt = S_IDLE;
                else if (w_pix_last) w_state_nxt = S_FIN;
                else                 w_state_nxt = S_RD_A;
            end
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Control outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_mem_req <= 1'b0;
            r_mem_sel <= 1'b0;
        end else begin
            r_busy    <= (w_state_nxt != S_IDLE);
            r_done    <= (w_state_nxt == S_FIN);
            r_mem_req <= (w_state_nxt == S_RD_A) || (w_state_nxt == S_RD_B);
            r_mem_sel <= (w_state_nxt == S_RD_B);
        end
    end

    // Run parameters, pixel index, pixel registers, accumulators and verdict.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_width    <= 10'd0;
            r_height   <= 10'd0;
            r_thresh   <= {(ACC_W+2){1'b0}};
            r_pix      <= {AW{1'b0}};
            r_last     <= 20'd0;
            r_pix_a    <= 24'd0;
            r_pix_b    <= 24'd0;
            r_sum_r    <= {ACC_W{1'b0}};
            r_sum_g    <= {ACC_W{1'b0}};
            r_sum_b    <= {ACC_W{1'b0}};
            r_total    <= {(ACC_W+2){1'b0}};
            r_match    <= 1'b0;
            r_size_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_width    <= width;
                        r_height   <= height;
                        r_thresh   <= thresh;
                        r_sum_r    <= {ACC_W{1'b0}};
                        r_sum_g    <= {ACC_W{1'b0}};
                        r_sum_b    <= {ACC_W{1'b0}};
                        r_total    <= {(ACC_W+2){1'b0}};
                        r_match    <= 1'b0;
                        r_size_err <= 1'b0;
                    end
                end
                S_CHK: begin
                    if (!abort) begin
                        if (w_size_bad) begin
                            r_size_err <= 1'b1;
                        end else begin
                            r_pix  <= {AW{1'b0}};
                            r_last <= w_last;
                        end
                    end
                end
                S_RD_A: begin
                    if (!abort && mem_ack) r_pix_a <= mem_rdata;
                end
                S_RD_B: begin
                    if (!abort && mem_ack) r_pix_b <= mem_rdata;
                end
                S_ACC: begin
                    if (!abort) begin
                        r_sum_r <= w_sum_r_nxt;
                        r_sum_g <= w_sum_g_nxt;
                        r_sum_b <= w_sum_b_nxt;
                        r_total <= w_total_nxt;
                        // Verdict is taken on the final total so it is valid during FIN.
                        if (w_pix_last) r_match <= (w_total_nxt <= r_thresh);
                        else            r_pix   <= r_pix + {{(AW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign size_err = r_size_err;
    assign mem_req  = r_mem_req;
    assign mem_sel  = r_mem_sel;
    assign mem_addr = r_pix;
    assign sum_r    = r_sum_r;
    assign sum_g    = r_sum_g;
    assign sum_b    = r_sum_b;
    assign total    = r_total;
    assign match    = r_match;

endmodule

// File: tb/tb_img_cmp_ctrl.sv
// Self-checking bench for img_cmp_ctrl: directed table, random frames against an
// arithmetic reference model, and abort / restart / reset sequences.
module tb_img_cmp_ctrl;

    logic        clk = 1'b0;
    logic        resetn, start, abort, mem_ack;
    logic [9:0]  width, height;
    logic [37:0] thresh, total;
    logic        busy, done, size_err, mem_req, mem_sel, match;
    logic [18:0] mem_addr;
    logic [23:0] mem_rdata;
    logic [35:0] sum_r, sum_g, sum_b;

    always #5 clk = ~clk;

    img_cmp_ctrl dut (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort),
        .width(width), .height(height), .thresh(thresh),
        .busy(busy), .done(done), .size_err(size_err),
        .mem_req(mem_req), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .sum_r(sum_r), .sum_g(sum_g), .sum_b(sum_b), .total(total), .match(match)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [23:0] mem_a [64];
    logic [23:0] mem_b [64];
    int          max_delay = 0;
    int          waits = 0;
    int          unstable = 0;
    bit          pending = 1'b0;
    int          wait_left = 0;
    logic        pend_sel;
    logic [18:0] pend_addr;
    logic [19:0] req_log [$];

    // Memory responder: random ack latency, data valid in the ack cycle.
    always @(negedge clk) begin
        if (resetn && mem_req) begin
            if (!pending) begin
                pending   = 1'b1;
                wait_left = $urandom_range(max_delay, 0);
                pend_sel  = mem_sel;
                pend_addr = mem_addr;
            end else if (pend_sel !== mem_sel || pend_addr !== mem_addr) begin
                unstable++;
            end
            if (wait_left == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = (mem_addr < 19'd64) ? (mem_sel ? mem_b[mem_addr[5:0]] : mem_a[mem_addr[5:0]]) : 24'd0;
                req_log.push_back({mem_sel, mem_addr});
                pending   = 1'b0;
            end else begin
                wait_left--;
                mem_ack   = 1'b0;
                mem_rdata = 24'($urandom);
                waits++;
            end
        end else begin
            mem_ack = 1'b0;
            pending = 1'b0;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    longint m_r, m_g, m_b;

    // Reference: plain sum of squared channel differences over the first n pixels.
    task automatic model(input int n);
        int d;
        m_r = 0; m_g = 0; m_b = 0;
        for (int i = 0; i < n; i++) begin
            d = int'(mem_a[i][23:16]) - int'(mem_b[i][23:16]); m_r += d * d;
            d = int'(mem_a[i][15:8])  - int'(mem_b[i][15:8]);  m_g += d * d;
            d = int'(mem_a[i][7:0])   - int'(mem_b[i][7:0]);   m_b += d * d;
        end
    endtask

    int          got_done_cyc, got_ndone, got_req, end_cyc, abort_cyc;
    logic [35:0] g_r, g_g, g_b;
    logic [37:0] g_tot;
    logic        g_match, g_serr;

    // mode: 0 plain, 1 abort at pixel 2 RD_B, 2 extra start mid-run, 3 reset mid-run.
    task automatic run_frame(input logic [9:0] w, input logic [9:0] h, input logic [37:0] thr, input int mode);
        int budget;
        bit abort_sent;
        budget = 3 * int'(w) * int'(h) * (max_delay + 1) + 20;
        got_done_cyc = -1; got_ndone = 0; got_req = 0; end_cyc = -1; abort_cyc = -1;
        abort_sent = 1'b0;
        g_r = '0; g_g = '0; g_b = '0; g_tot = '0; g_match = 1'b0; g_serr = 1'b0;
        @(negedge clk);
        req_log.delete(); waits = 0; unstable = 0;
        width = w; height = h; thresh = thr; start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        width  = 10'($urandom);
        height = 10'($urandom);
        thresh = 38'($urandom);
        for (int c = 1; c <= budget; c++) begin
            if (abort) abort = 1'b0;
            if (mode == 2) start = (c == 6);
            if (done) begin
                got_ndone++;
                if (got_done_cyc < 0) begin
                    got_done_cyc = c;
                    g_r = sum_r; g_g = sum_g; g_b = sum_b; g_tot = total;
                    g_match = match; g_serr = size_err;
                end
            end
            if (mem_req) got_req++;
            if (!busy) begin
                end_cyc = c;
                break;
            end
            if (mode == 1 && !abort_sent && mem_req && mem_sel && mem_addr == 19'd2) begin
                abort = 1'b1; abort_sent = 1'b1; abort_cyc = c;
            end
            if (mode == 3 && c == 6) begin
                resetn = 1'b0;
                #1;
                check("rst_ctrl", {busy, done, size_err, mem_req, mem_sel, match}, 64'd0);
                check("rst_addr", mem_addr, 64'd0);
                check("rst_sums", {sum_r | sum_g | sum_b}, 64'd0);
                check("rst_total", total, 64'd0);
                end_cyc = c;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
        if (end_cyc < 0) begin
            check("run_timeout", busy, 64'd0);
            resetn = 1'b0;
            @(negedge clk);
            resetn = 1'b1;
        end
    endtask

    task automatic check_run(input string tag, input int n, input logic eserr, input logic ematch,
                             input longint er, input longint eg, input longint eb, input int edone);
        int errs;
        check({tag, "_ndone"}, got_ndone, 64'd1);
        check({tag, "_done_cyc"}, got_done_cyc, edone);
        check({tag, "_sum_r"}, g_r, er);
        check({tag, "_sum_g"}, g_g, eg);
        check({tag, "_sum_b"}, g_b, eb);
        check({tag, "_total"}, g_tot, er + eg + eb);
        check({tag, "_match"}, g_match, ematch);
        check({tag, "_size_err"}, g_serr, eserr);
        if (eserr) begin
            check({tag, "_no_req"}, got_req, 64'd0);
        end else begin
            errs = (req_log.size() == 2 * n) ? 0 : 1;
            for (int i = 0; i < req_log.size() && i < 2 * n; i++)
                if (req_log[i] !== {i[0], 19'(i >> 1)}) errs++;
            check({tag, "_addr_order"}, errs, 64'd0);
            check({tag, "_req_cycles"}, got_req, 2 * n + waits);
            check({tag, "_addr_stable"}, unstable, 64'd0);
        end
    endtask

    typedef struct {
        logic [9:0]  w, h;
        logic [37:0] thr;
        logic [95:0] pa, pb;
        logic        eserr, ematch;
        longint      er, eg, eb;
        int          edone;
    } vec_t;

    vec_t tv [8];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint tot;
        int     n, w, h, dl;
        logic [37:0] thr;

        tv[0] = '{w:10'd2, h:10'd2, thr:38'd0,
                  pa:{24'h7F7F7F, 24'h00FF80, 24'hABCDEF, 24'h123456},
                  pb:{24'h7F7F7F, 24'h00FF80, 24'hABCDEF, 24'h123456},
                  eserr:1'b0, ematch:1'b1, er:0, eg:0, eb:0, edone:14};
        tv[1] = '{w:10'd1, h:10'd1, thr:38'd65024, pa:{72'd0, 24'hFF0000}, pb:96'd0,
                  eserr:1'b0, ematch:1'b0, er:65025, eg:0, eb:0, edone:5};
        tv[2] = '{w:10'd1, h:10'd1, thr:38'd65025, pa:{72'd0, 24'hFF0000}, pb:96'd0,
                  eserr:1'b0, ematch:1'b1, er:65025, eg:0, eb:0, edone:5};
        tv[3] = '{w:10'd2, h:10'd1, thr:38'd1450, pa:{48'd0, 24'h000000, 24'h0A141E},
                  pb:{48'd0, 24'h030405, 24'h000000},
                  eserr:1'b0, ematch:1'b1, er:109, eg:416, eb:925, edone:8};
        tv[4] = '{w:10'd0, h:10'd4, thr:38'h3F_FFFF_FFFF, pa:96'd0, pb:96'd0,
                  eserr:1'b1, ematch:1'b0, er:0, eg:0, eb:0, edone:2};
        tv[5] = '{w:10'd641, h:10'd1, thr:38'h3F_FFFF_FFFF, pa:96'd0, pb:96'd0,
                  eserr:1'b1, ematch:1'b0, er:0, eg:0, eb:0, edone:2};
        tv[6] = '{w:10'd1, h:10'd481, thr:38'd100, pa:96'd0, pb:96'd0,
                  eserr:1'b1, ematch:1'b0, er:0, eg:0, eb:0, edone:2};
        tv[7] = '{w:10'd640, h:10'd0, thr:38'd100, pa:96'd0, pb:96'd0,
                  eserr:1'b1, ematch:1'b0, er:0, eg:0, eb:0, edone:2};

        resetn = 1'b0; start = 1'b0; abort = 1'b0; mem_ack = 1'b0; mem_rdata = 24'd0;
        width = 10'd0; height = 10'd0; thresh = 38'd0;
        for (int i = 0; i < 64; i++) begin mem_a[i] = 24'd0; mem_b[i] = 24'd0; end
        repeat (3) @(negedge clk);
        check("reset_ctrl", {busy, done, size_err, mem_req, mem_sel, match}, 64'd0);
        check("reset_addr", mem_addr, 64'd0);
        check("reset_total", total, 64'd0);
        resetn = 1'b1;

        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 4; i++) begin
                mem_a[i] = tv[k].pa[i*24 +: 24];
                mem_b[i] = tv[k].pb[i*24 +: 24];
            end
            max_delay = 0;
            run_frame(tv[k].w, tv[k].h, tv[k].thr, 0);
            check_run($sformatf("vec%0d", k), int'(tv[k].w) * int'(tv[k].h), tv[k].eserr, tv[k].ematch,
                      tv[k].er, tv[k].eg, tv[k].eb, tv[k].edone);
        end

        // The 2x1 case again under random ack latency.
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 4; i++) begin
                mem_a[i] = tv[3].pa[i*24 +: 24];
                mem_b[i] = tv[3].pb[i*24 +: 24];
            end
            max_delay = 3;
            run_frame(tv[3].w, tv[3].h, tv[3].thr, 0);
            check_run($sformatf("slow%0d", k), 2, 1'b0, 1'b1, 109, 416, 925, 8 + waits);
        end

        for (int k = 0; k < 16; k++) begin
            w = $urandom_range(6, 1); h = $urandom_range(6, 1); n = w * h;
            for (int i = 0; i < n; i++) begin
                mem_a[i] = 24'($urandom);
                mem_b[i] = ($urandom_range(3, 0) == 0) ? mem_a[i] : 24'($urandom);
            end
            model(n);
            tot = m_r + m_g + m_b;
            dl  = $urandom_range(2, 0);
            thr = (tot == 0 && dl == 0) ? 38'd0 : 38'(tot + dl - 1);
            max_delay = $urandom_range(3, 0);
            run_frame(10'(w), 10'(h), thr, 0);
            check_run($sformatf("rnd%0d", k), n, 1'b0, (tot <= longint'(thr)), m_r, m_g, m_b, 3 * n + 2 + waits);
        end

        // Abort during the third pixel's B read.
        for (int i = 0; i < 16; i++) begin mem_a[i] = 24'($urandom); mem_b[i] = ~mem_a[i]; end
        max_delay = 0;
        run_frame(10'd4, 10'd4, 38'h3F_FFFF_FFFF, 1);
        model(2);
        check("abort_cycle", abort_cyc, 64'd9);
        check("abort_idle_next", end_cyc, 64'd10);
        check("abort_no_done", got_ndone, 64'd0);
        check("abort_sum_r", sum_r, m_r);
        check("abort_sum_g", sum_g, m_g);
        check("abort_sum_b", sum_b, m_b);
        check("abort_total", total, m_r + m_g + m_b);
        check("abort_match", match, 64'd0);

        // A start pulse mid-run must be ignored.
        for (int i = 0; i < 4; i++) begin mem_a[i] = 24'($urandom); mem_b[i] = 24'($urandom); end
        model(4);
        run_frame(10'd2, 10'd2, 38'h3F_FFFF_FFFF, 2);
        check_run("midstart", 4, 1'b0, 1'b1, m_r, m_g, m_b, 14);

        // Asynchronous reset mid-run, then a clean run from pixel 0.
        run_frame(10'd2, 10'd2, 38'd0, 3);
        @(negedge clk);
        resetn = 1'b1;
        run_frame(10'd2, 10'd2, 38'd0, 0);
        check_run("post_reset", 4, 1'b0, (m_r + m_g + m_b == 0), m_r, m_g, m_b, 14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
